// File: rtl/bht_update_sched_if.sv
// Handshake bundle between the branch-resolve requesters, the scheduler and the bht update port.
interface bht_update_sched_if #(
  parameter int unsigned VLEN = 64
);
  logic [1:0]           req_valid_i;
  logic [1:0][VLEN-1:0] req_pc_i;
  logic [1:0]           req_taken_i;
  logic [1:0]           req_ready_o;
  logic                 bht_ready_i;
  logic                 bht_valid_o;
  logic [VLEN-1:0]      bht_pc_o;
  logic                 bht_taken_o;

  modport master (
    output req_valid_i, req_pc_i, req_taken_i, bht_ready_i,
    input  req_ready_o, bht_valid_o, bht_pc_o, bht_taken_o
  );

  modport slave (
    input  req_valid_i, req_pc_i, req_taken_i, bht_ready_i,
    output req_ready_o, bht_valid_o, bht_pc_o, bht_taken_o
  );
endinterface

// File: rtl/bht_update_sched.sv
// Round-robin arbiter of two branch-resolution update sources into a small FIFO feeding the bht
// update port; drops (and counts) updates in debug mode and clears the queue on flush.
module bht_update_sched #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VLEN  = 64,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     debug_mode_i,
  bht_update_sched_if.slave        bus,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [VLEN-1:0]  pc_q [DEPTH];
  logic [DEPTH-1:0] taken_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] count_q;
  logic             rr_q;

  logic       full_c, empty_c, grant_en_c, gnt_idx_c;
  logic [1:0] gnt_c;
  logic       accept_c, enq_c, deq_c;

  // Grant selection: single valid wins outright, a tie goes to rr_q.
  always_comb begin
    full_c     = (count_q == OCC_W'(DEPTH));
    empty_c    = (count_q == '0);
    grant_en_c = rst_ni & ~flush_i & ~full_c;
    gnt_c      = '0;
    gnt_idx_c  = rr_q;
    if (grant_en_c) begin
      unique case (bus.req_valid_i)
        2'b01: begin gnt_c = 2'b01; gnt_idx_c = 1'b0; end
        2'b10: begin gnt_c = 2'b10; gnt_idx_c = 1'b1; end
        2'b11: begin gnt_c = rr_q ? 2'b10 : 2'b01; gnt_idx_c = rr_q; end
        default: begin gnt_c = '0; gnt_idx_c = rr_q; end
      endcase
    end
    accept_c = |gnt_c;
    enq_c    = accept_c & ~debug_mode_i;
    deq_c    = bus.bht_valid_o & bus.bht_ready_i & ~flush_i;
  end

  assign bus.req_ready_o = gnt_c;
  assign bus.bht_valid_o = ~empty_c & ~debug_mode_i;
  assign bus.bht_pc_o    = pc_q[rd_ptr_q];
  assign bus.bht_taken_o = taken_q[rd_ptr_q];
  assign occupancy_o     = count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) pc_q[i] <= '0;
      taken_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_q       <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      if (accept_c) rr_q <= ~gnt_idx_c;
      if (accept_c && debug_mode_i && (drop_cnt_o != {CNT_W{1'b1}}))
        drop_cnt_o <= drop_cnt_o + CNT_W'(1);
      // Flush wins over any enqueue/dequeue in the same cycle.
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (enq_c) begin
          pc_q[wr_ptr_q]    <= bus.req_pc_i[gnt_idx_c];
          taken_q[wr_ptr_q] <= bus.req_taken_i[gnt_idx_c];
          wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
        end
        if (deq_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        unique case ({enq_c, deq_c})
          2'b10:   count_q <= count_q + OCC_W'(1);
          2'b01:   count_q <= count_q - OCC_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end
endmodule
